// File: rtl/eth_pcs_rx_block_sync_pkg.sv
// Shared 10G PCS receive parameters and the block-sync state type.
package eth_pcs_rx_block_sync_pkg;

  localparam int unsigned W_SYNC    = 2;
  localparam logic [1:0]  SYNC_DATA = 2'b01;
  localparam logic [1:0]  SYNC_CTRL = 2'b10;

  localparam int unsigned SH_VAL_TH     = 64;
  localparam int unsigned W_SH_VAL_TH   = $clog2(SH_VAL_TH);
  localparam int unsigned SH_INVAL_TH   = 16;
  localparam int unsigned W_SH_INVAL_TH = $clog2(SH_INVAL_TH);

  typedef enum logic [1:0] {
    HUNT,
    SLIP,
    LOCKED
  } blk_sync_state_t;

endpackage

// File: rtl/eth_pcs_rx_block_sync.sv
// 64b/66b block synchronizer: tracks sync-header validity, requests gearbox
// bit slips while hunting and reports block lock to the decoder.
module eth_pcs_rx_block_sync #(
  parameter int unsigned SH_VAL_TH   = eth_pcs_rx_block_sync_pkg::SH_VAL_TH,
  parameter int unsigned SH_INVAL_TH = eth_pcs_rx_block_sync_pkg::SH_INVAL_TH,
  parameter int unsigned SLIP_WAIT   = 2
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         i_hdr_valid,
  input  logic [eth_pcs_rx_block_sync_pkg::W_SYNC-1:0] i_sync_hdr,
  output logic                                         o_slip,
  output logic                                         o_block_lock,
  output logic [$clog2(SH_INVAL_TH):0]                 o_sh_inval_cnt
);
  import eth_pcs_rx_block_sync_pkg::*;

  localparam int unsigned CNT_W  = $clog2(SH_VAL_TH);
  localparam int unsigned INV_W  = $clog2(SH_INVAL_TH) + 1;
  localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [CNT_W-1:0]  SH_CNT_MAX = CNT_W'(SH_VAL_TH - 1);
  localparam logic [INV_W-1:0]  INV_LIMIT  = INV_W'(SH_INVAL_TH);
  localparam logic [WAIT_W-1:0] WAIT_LOAD  = WAIT_W'(SLIP_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(1);

  blk_sync_state_t   state_q, state_d;
  logic [CNT_W-1:0]  sh_cnt_q, sh_cnt_d;
  logic [INV_W-1:0]  inval_q, inval_d, inval_inc;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              lock_q, lock_d;
  logic              slip_q, slip_d;
  logic              hdr_ok;

  assign hdr_ok = (i_sync_hdr == SYNC_DATA) || (i_sync_hdr == SYNC_CTRL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      sh_cnt_q <= '0;
      inval_q  <= '0;
      wait_q   <= '0;
      lock_q   <= 1'b0;
      slip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_cnt_q <= sh_cnt_d;
      inval_q  <= inval_d;
      wait_q   <= wait_d;
      lock_q   <= lock_d;
      slip_q   <= slip_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sh_cnt_d  = sh_cnt_q;
    inval_d   = inval_q;
    wait_d    = wait_q;
    lock_d    = lock_q;
    slip_d    = 1'b0;
    inval_inc = inval_q + {{(INV_W-1){1'b0}}, ~hdr_ok};

    if (i_hdr_valid) begin
      unique case (state_q)
        HUNT: begin
          if (hdr_ok) begin
            if (sh_cnt_q == SH_CNT_MAX) begin
              state_d  = LOCKED;
              sh_cnt_d = '0;
              inval_d  = '0;
              lock_d   = 1'b1;
            end else begin
              sh_cnt_d = sh_cnt_q + 1'b1;
            end
          end else begin
            state_d  = SLIP;
            slip_d   = 1'b1;
            sh_cnt_d = '0;
            wait_d   = WAIT_LOAD;
          end
        end

        SLIP: begin
          // Headers here come from a gearbox still settling; only count them.
          wait_d = wait_q - 1'b1;
          if (wait_q == WAIT_LAST) begin
            state_d = HUNT;
          end
        end

        LOCKED: begin
          // Loss of lock outranks the window-end clear on the same strobe.
          if (!hdr_ok && (inval_inc == INV_LIMIT)) begin
            state_d  = SLIP;
            lock_d   = 1'b0;
            slip_d   = 1'b1;
            sh_cnt_d = '0;
            inval_d  = '0;
            wait_d   = WAIT_LOAD;
          end else if (sh_cnt_q == SH_CNT_MAX) begin
            sh_cnt_d = '0;
            inval_d  = '0;
          end else begin
            sh_cnt_d = sh_cnt_q + 1'b1;
            inval_d  = inval_inc;
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  assign o_slip         = slip_q;
  assign o_block_lock   = lock_q;
  assign o_sh_inval_cnt = inval_q;

endmodule

// File: tb/tb_eth_pcs_rx_block_sync.sv
// Scenario bench for the block synchronizer: expected outputs are queued as
// each cycle is driven and compared once the registered outputs settle.
module tb_eth_pcs_rx_block_sync;
  import eth_pcs_rx_block_sync_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_hdr_valid;
  logic [1:0] i_sync_hdr;
  logic       o_slip;
  logic       o_block_lock;
  logic [4:0] o_sh_inval_cnt;

  int unsigned passes = 0;
  int unsigned total  = 0;
  logic [6:0]  sb[$];
  logic [6:0]  exp_v;

  always #5 clk = ~clk;

  eth_pcs_rx_block_sync #(
    .SH_VAL_TH  (64),
    .SH_INVAL_TH(16),
    .SLIP_WAIT  (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_hdr_valid   (i_hdr_valid),
    .i_sync_hdr    (i_sync_hdr),
    .o_slip        (o_slip),
    .o_block_lock  (o_block_lock),
    .o_sh_inval_cnt(o_sh_inval_cnt)
  );

  function automatic logic [6:0] pk(input logic l, input logic s, input int unsigned inv);
    logic [4:0] iv;
    iv = inv[4:0];
    return {l, s, iv};
  endfunction

  task automatic cyc(input logic v, input logic [1:0] h);
    i_hdr_valid = v;
    i_sync_hdr  = h;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 2'b00);
    rst = 1'b0;
  endtask

  task automatic lock_up();
    do_reset();
    for (int i = 0; i < 64; i++) cyc(1'b1, SYNC_DATA);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(pk(1'b0, 1'b0, 0));
      cyc(1'b1, 2'(i));
      exp_v = sb.pop_front();
      total++;
      if ({o_block_lock, o_slip, o_sh_inval_cnt} !== exp_v)
        $display("FAIL reset[%0d]: lock/slip/inval got %b/%b/%0d expected %b/%b/%0d", i,
                 o_block_lock, o_slip, o_sh_inval_cnt, exp_v[6], exp_v[5], exp_v[4:0]);
      else passes++;
    end
    rst = 1'b0;
  endtask

  task automatic test_acquire();
    do_reset();
    for (int i = 1; i <= 65; i++) begin
      sb.push_back(pk(i >= 64, 1'b0, 0));
      if (i <= 64) cyc(1'b1, SYNC_DATA);
      else cyc(1'b0, 2'b11);
      exp_v = sb.pop_front();
      total++;
      if ({o_block_lock, o_slip, o_sh_inval_cnt} !== exp_v)
        $display("FAIL acquire[%0d]: lock/slip/inval got %b/%b/%0d expected %b/%b/%0d", i,
                 o_block_lock, o_slip, o_sh_inval_cnt, exp_v[6], exp_v[5], exp_v[4:0]);
      else passes++;
    end
  endtask

  task automatic test_hunt_slip();
    logic [1:0] h;
    do_reset();
    // 10 good, 1 bad (slip), 2 ignored 00s, then 64 good to relock
    for (int i = 1; i <= 77; i++) begin
      if (i <= 10) h = (i % 2 == 1) ? SYNC_DATA : SYNC_CTRL;
      else if (i == 11) h = 2'b11;
      else if (i <= 13) h = 2'b00;
      else h = (i % 2 == 1) ? SYNC_CTRL : SYNC_DATA;
      sb.push_back(pk(i == 77, i == 11, 0));
      cyc(1'b1, h);
      exp_v = sb.pop_front();
      total++;
      if ({o_block_lock, o_slip, o_sh_inval_cnt} !== exp_v)
        $display("FAIL hunt_slip[%0d]: lock/slip/inval got %b/%b/%0d expected %b/%b/%0d", i,
                 o_block_lock, o_slip, o_sh_inval_cnt, exp_v[6], exp_v[5], exp_v[4:0]);
      else passes++;
    end
  endtask

  task automatic test_window();
    logic [1:0] h;
    int unsigned inv;
    lock_up();
    for (int i = 1; i <= 65; i++) begin
      if (i <= 15 || i == 65) h = (i % 2 == 1) ? 2'b00 : 2'b11;
      else h = SYNC_DATA;
      if (i == 64) inv = 0;
      else if (i == 65) inv = 1;
      else if (i < 15) inv = i;
      else inv = 15;
      sb.push_back(pk(1'b1, 1'b0, inv));
      cyc(1'b1, h);
      exp_v = sb.pop_front();
      total++;
      if ({o_block_lock, o_slip, o_sh_inval_cnt} !== exp_v)
        $display("FAIL window[%0d]: lock/slip/inval got %b/%b/%0d expected %b/%b/%0d", i,
                 o_block_lock, o_slip, o_sh_inval_cnt, exp_v[6], exp_v[5], exp_v[4:0]);
      else passes++;
    end
  endtask

  task automatic test_lock_loss();
    lock_up();
    // 10 good, 16 bad (loss on 16th), 2 ignored, then a bad header slips again
    for (int i = 1; i <= 29; i++) begin
      if (i <= 10) begin
        sb.push_back(pk(1'b1, 1'b0, 0));
        cyc(1'b1, SYNC_CTRL);
      end else if (i <= 26) begin
        sb.push_back((i < 26) ? pk(1'b1, 1'b0, i - 10) : pk(1'b0, 1'b1, 0));
        cyc(1'b1, 2'b11);
      end else if (i <= 28) begin
        sb.push_back(pk(1'b0, 1'b0, 0));
        cyc(1'b1, SYNC_DATA);
      end else begin
        sb.push_back(pk(1'b0, 1'b1, 0));
        cyc(1'b1, 2'b00);
      end
      exp_v = sb.pop_front();
      total++;
      if ({o_block_lock, o_slip, o_sh_inval_cnt} !== exp_v)
        $display("FAIL lock_loss[%0d]: lock/slip/inval got %b/%b/%0d expected %b/%b/%0d", i,
                 o_block_lock, o_slip, o_sh_inval_cnt, exp_v[6], exp_v[5], exp_v[4:0]);
      else passes++;
    end
  endtask

  task automatic test_priority();
    lock_up();
    // 48 good then 16 bad: the 16th bad header is strobe 64 of the window
    for (int i = 1; i <= 65; i++) begin
      if (i <= 48) begin
        sb.push_back(pk(1'b1, 1'b0, 0));
        cyc(1'b1, SYNC_DATA);
      end else if (i <= 64) begin
        sb.push_back((i < 64) ? pk(1'b1, 1'b0, i - 48) : pk(1'b0, 1'b1, 0));
        cyc(1'b1, 2'b00);
      end else begin
        sb.push_back(pk(1'b0, 1'b0, 0));
        cyc(1'b0, 2'b01);
      end
      exp_v = sb.pop_front();
      total++;
      if ({o_block_lock, o_slip, o_sh_inval_cnt} !== exp_v)
        $display("FAIL priority[%0d]: lock/slip/inval got %b/%b/%0d expected %b/%b/%0d", i,
                 o_block_lock, o_slip, o_sh_inval_cnt, exp_v[6], exp_v[5], exp_v[4:0]);
      else passes++;
    end
  endtask

  task automatic test_gaps_reset();
    int unsigned n;
    lock_up();
    // Invalid strobes separated by idle cycles carrying garbage headers
    for (int k = 1; k <= 6; k++) begin
      n = $urandom_range(1, 3);
      for (int g = 0; g <= int'(n); g++) begin
        sb.push_back(pk(1'b1, 1'b0, k));
        if (g == 0) cyc(1'b1, 2'b00);
        else cyc(1'b0, 2'($urandom_range(0, 3)));
        exp_v = sb.pop_front();
        total++;
        if ({o_block_lock, o_slip, o_sh_inval_cnt} !== exp_v)
          $display("FAIL gaps_locked[%0d.%0d]: lock/slip/inval got %b/%b/%0d expected %b/%b/%0d",
                   k, g, o_block_lock, o_slip, o_sh_inval_cnt, exp_v[6], exp_v[5], exp_v[4:0]);
        else passes++;
      end
    end

    do_reset();
    for (int k = 1; k <= 30; k++) begin
      sb.push_back(pk(1'b0, 1'b0, 0));
      if (k % 2 == 1) cyc(1'b1, SYNC_DATA);
      else cyc(1'b0, 2'($urandom_range(0, 3)));
      exp_v = sb.pop_front();
      total++;
      if ({o_block_lock, o_slip, o_sh_inval_cnt} !== exp_v)
        $display("FAIL gaps_hunt[%0d]: lock/slip/inval got %b/%b/%0d expected %b/%b/%0d", k,
                 o_block_lock, o_slip, o_sh_inval_cnt, exp_v[6], exp_v[5], exp_v[4:0]);
      else passes++;
    end

    // Slip, then reset while the wait is still pending; 64 strobes must relock
    for (int k = 0; k <= 65; k++) begin
      if (k == 0) begin
        sb.push_back(pk(1'b0, 1'b1, 0));
        cyc(1'b1, 2'b11);
      end else if (k == 1) begin
        rst = 1'b1;
        sb.push_back(pk(1'b0, 1'b0, 0));
        cyc(1'b1, 2'b00);
        rst = 1'b0;
      end else begin
        sb.push_back(pk(k == 65, 1'b0, 0));
        cyc(1'b1, SYNC_DATA);
      end
      exp_v = sb.pop_front();
      total++;
      if ({o_block_lock, o_slip, o_sh_inval_cnt} !== exp_v)
        $display("FAIL slip_reset[%0d]: lock/slip/inval got %b/%b/%0d expected %b/%b/%0d", k,
                 o_block_lock, o_slip, o_sh_inval_cnt, exp_v[6], exp_v[5], exp_v[4:0]);
      else passes++;
    end
  endtask

  initial begin
    rst         = 1'b1;
    i_hdr_valid = 1'b0;
    i_sync_hdr  = 2'b00;
    test_reset();
    test_acquire();
    test_hunt_slip();
    test_window();
    test_lock_loss();
    test_priority();
    test_gaps_reset();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/eth_pcs_rx_block_sync.md
# eth_pcs_rx_block_sync

Receive-side 64b/66b block synchronizer for the 10G PCS. It consumes the 2-bit sync header that the RX gearbox extracts once per 66-bit block, and runs the block-lock state machine using the shared valid/invalid thresholds. It also issues single-cycle slip requests back to the RX gearbox until header alignment is found. Its outputs drive the descrambler/decoder qualification (`o_block_lock`) and the gearbox bit offset (`o_slip`).

## Interface
- `SH_VAL_TH`, 64: consecutive valid headers needed to acquire lock; also the length of the monitoring window while locked.
- `SH_INVAL_TH`, 16: invalid headers within one window that cause loss of lock.
- `SLIP_WAIT`, 2: header strobes ignored after each slip while the gearbox realigns; must be ≥1.
- `clk` in 1: PCS RX clock.
- `rst` in 1: synchronous, active-high reset.
- `i_hdr_valid` in 1: qualifies `i_sync_hdr`; at most one strobe per block.
- `i_sync_hdr` in `W_SYNC`: sync header of the current block.
- `o_slip` out 1: one-cycle request to the gearbox to shift alignment by one bit.
- `o_block_lock` out 1: block lock is held.
- `o_sh_inval_cnt` out `W_SH_INVAL_TH+1`: invalid count in the current window, for debug.

## Operation
- A header is valid when it equals `SYNC_DATA` or `SYNC_CTRL`. A header of 2'b00 or 2'b11 is invalid.
- The state machine evaluates only on cycles where `i_hdr_valid`=1. On all other cycles the state and counters hold.
- States and transitions:
  - **HUNT**: `o_block_lock`=0.
    - Valid header: increment `sh_cnt`. If `sh_cnt`==`SH_VAL_TH`-1, go to LOCKED, clear counters and set lock.
    - Invalid header: pulse `o_slip`, clear `sh_cnt`, load `wait_cnt`=`SLIP_WAIT`, go to SLIP.
  - **SLIP**: each strobe decrements `wait_cnt`; the header is not evaluated. When `wait_cnt` reaches 0, go to HUNT.
  - **LOCKED**: each strobe increments `sh_cnt`. An invalid header also increments `sh_inval_cnt`.
    - If the invalid increment makes `sh_inval_cnt`==`SH_INVAL_TH`: clear lock, pulse `o_slip`, clear counters, go to SLIP. This takes priority over window end.
    - Otherwise, if `sh_cnt`==`SH_VAL_TH`-1 (window end): clear both counters and stay LOCKED.
- `sh_cnt` width is `W_SH_VAL_TH`; its top value is `SH_VAL_TH`-1 and it never wraps. `sh_inval_cnt` width is `W_SH_INVAL_TH`+1.
- While in HUNT, a single invalid header always slips, because unlocked tolerance is zero.

## Timing
- All outputs are registered and update on the cycle after the qualifying strobe.
- `o_slip` is high for exactly one cycle per slip. A new slip cannot occur until `SLIP_WAIT` strobes have been consumed.
- Lock acquisition: `o_block_lock` rises one cycle after the `SH_VAL_TH`-th consecutive valid strobe.
- Lock loss: `o_block_lock` falls in the same cycle that `o_slip` pulses.
- Reset values: state=HUNT, `o_block_lock`=0, `o_slip`=0, all counters 0.
- `rst` asserted mid-operation returns to these values on the next edge, regardless of state or pending wait.
- `i_sync_hdr` is ignored when `i_hdr_valid`=0.

## Structure
- The shared PCS parameter package supplies `W_SYNC`, `SYNC_DATA`, `SYNC_CTRL`, `SH_VAL_TH`, `W_SH_VAL_TH`, `SH_INVAL_TH` and `W_SH_INVAL_TH` (=`$clog2(SH_INVAL_TH)`).
- The package also gains the state enum type `blk_sync_state_t` {HUNT, SLIP, LOCKED}.
- Single module; no sub-module.
- Header-validity decode is one local combinational signal.

## Test plan
- **Acquire lock**: 64 `SYNC_DATA` strobes after reset -> `o_block_lock`=1 the cycle after strobe 64. With 63 strobes it stays 0, and `o_slip` is never asserted.
- **Hunt slip**: 10 valid headers, then 2'b11 -> `o_slip` high for one cycle after the bad strobe.
  - The next 2 strobes are ignored, even if they carry 2'b00.
  - The count then restarts, and 64 further valid headers are needed to lock.
- **Window tolerance**: while locked, 15 invalid headers in a 64-strobe window -> lock held. At window end `o_sh_inval_cnt` returns to 0.
- **Lock loss**: while locked, 16 invalid headers within 64 strobes -> `o_block_lock`=0 and `o_slip`=1 in the same cycle, after the 16th invalid strobe.
- **Priority**: the 16th invalid header lands on strobe 64 of the window -> lock is lost; the window-reset path is not taken.
- **Gaps and reset**: random `i_hdr_valid` gaps with garbage `i_sync_hdr` produce no state change. Asserting `rst` during SLIP clears all outputs to 0 and returns to HUNT on the next edge.
